// File: rtl/nvram_store_ctrl.sv
// Store/recall sequencer for the NVRAM charge-pump macro: drives enables, BUSYNVC,
// VSESTART, RCLT and trim, and supervises the VSEBUSY handshake with timeouts.
module nvram_store_ctrl #(
  parameter int SETUP_CYCLES  = 4,
  parameter int START_CYCLES  = 8,
  parameter int ACK_TIMEOUT   = 64,
  parameter int STORE_TIMEOUT = 4096,
  parameter int RECALL_CYCLES = 32,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        store_req,
  input  logic        recall_req,
  input  logic [1:0]  mem_sel,
  input  logic [15:0] trim_in,
  input  logic [3:0]  tm_in,
  input  logic        vsebusy,
  output logic        mem1_ent,
  output logic        mem2_ent,
  output logic        busynvc,
  output logic        vsestart,
  output logic        rclt,
  output logic [15:0] trim,
  output logic [3:0]  tm_nvcpi,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    IDLE, SETUP, START, WAIT_ACK, WAIT_DONE, RECALL, FINISH
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LIM  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LIM  = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LIM    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STORE_LIM  = CNT_W'(STORE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RECALL_LIM = CNT_W'(RECALL_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             vb_m, vb_s;
  logic             is_recall;
  logic [1:0]       msel_q;
  logic             req, accept;
  logic             err_set;
  logic [1:0]       err_code_nx;
  logic             pump_on;

  assign req    = store_req | recall_req;
  assign accept = (state == IDLE) && req && (mem_sel != 2'b00);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      vb_m      <= 1'b0;
      vb_s      <= 1'b0;
      is_recall <= 1'b0;
      msel_q    <= 2'b00;
      trim      <= '0;
      tm_nvcpi  <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      vb_m  <= vsebusy;
      vb_s  <= vb_m;
      state <= state_nx;
      // Timer restarts on every state change and saturates instead of wrapping.
      if (state_nx != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
      if (accept) begin
        trim      <= trim_in;
        tm_nvcpi  <= tm_in;
        msel_q    <= mem_sel;
        is_recall <= ~store_req;
        err       <= 1'b0;
        err_code  <= 2'b00;
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_code_nx;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    err_set     = 1'b0;
    err_code_nx = 2'b00;
    case (state)
      IDLE: begin
        if (req) begin
          if (mem_sel == 2'b00) begin
            err_set     = 1'b1;
            err_code_nx = 2'b11;
          end else begin
            state_nx = SETUP;
          end
        end
      end
      SETUP:
        if (cnt == SETUP_LIM) state_nx = is_recall ? RECALL : START;
      START:
        if (cnt == START_LIM) state_nx = WAIT_ACK;
      WAIT_ACK: begin
        // A pump that is already busy on entry is taken as the acknowledge.
        if (vb_s) begin
          state_nx = WAIT_DONE;
        end else if (cnt == ACK_LIM) begin
          state_nx    = IDLE;
          err_set     = 1'b1;
          err_code_nx = 2'b01;
        end
      end
      WAIT_DONE: begin
        if (!vb_s) begin
          state_nx = FINISH;
        end else if (cnt == STORE_LIM) begin
          state_nx    = IDLE;
          err_set     = 1'b1;
          err_code_nx = 2'b10;
        end
      end
      RECALL:
        if (cnt == RECALL_LIM) state_nx = FINISH;
      FINISH:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    pump_on  = (state == SETUP) || (state == START) || (state == WAIT_ACK) ||
               (state == WAIT_DONE) || (state == RECALL);
    mem1_ent = pump_on & msel_q[0];
    mem2_ent = pump_on & msel_q[1];
    busynvc  = pump_on;
    vsestart = (state == START);
    rclt     = (state == RECALL);
    busy     = (state != IDLE);
    done     = (state == FINISH);
  end

endmodule

// File: doc/nvram_store_ctrl.md
Name: nvram_store_ctrl

Overview:
Sequencer that sits directly upstream of the NVRAM charge-pump macro. It turns single-cycle store/recall requests from the housekeeping register block into the pump's control sequence (memory enables, BUSYNVC, VSESTART, RCLT, TRIM/TM values) and watches the pump's VSEBUSY handshake with timeouts. It reports busy, done and error status back to the host.

Parameters:
SETUP_CYCLES, 4, cycles that enables and trim are held stable before VSESTART rises
START_CYCLES, 8, width of the VSESTART pulse in cycles
ACK_TIMEOUT, 64, max cycles waiting for synchronized VSEBUSY to rise
STORE_TIMEOUT, 4096, max cycles VSEBUSY may stay high
RECALL_CYCLES, 32, width of the RCLT pulse in cycles
CNT_W, 16, timer width; must hold max(all above)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
store_req  input  1  one-cycle store request
recall_req  input  1  one-cycle recall request
mem_sel  input  2  bit0 = MEM1, bit1 = MEM2
trim_in  input  16  pump trim value from the register block
tm_in  input  4  pump test-mode value from the register block
vsebusy  input  1  pump VSEBUSY; asynchronous to clk
mem1_ent  output  1  to pump MEM1_ENT
mem2_ent  output  1  to pump MEM2_ENT
busynvc  output  1  to pump BUSYNVC
vsestart  output  1  to pump VSESTART
rclt  output  1  to pump RCLT
trim  output  16  to pump TRIM; registered
tm_nvcpi  output  4  to pump TM_NVCPI; registered
busy  output  1  high while any sequence is active
done  output  1  one-cycle pulse when a sequence completes without error
err  output  1  sticky error flag
err_code  output  2  00 none, 01 ack timeout, 10 store timeout, 11 bad mem_sel

Behaviour:
- Reset (resetn = 0 at a clk edge): state IDLE; all outputs 0, including trim, tm_nvcpi and err_code; synchronizer flops cleared.
- vsebusy passes through a 2-flop synchronizer (vb_s). All decisions use vb_s, which lags the pin by 2 cycles.
- States: IDLE, SETUP, START, WAIT_ACK, WAIT_DONE, RECALL, FINISH.
- IDLE, request sampled at edge N:
  - busy = 1 from N+1.
  - trim and tm_nvcpi latch trim_in and tm_in at N and stay frozen until the return to IDLE.
  - err and err_code clear on every accepted request.
- Arbitration: store_req and recall_req high in the same cycle -> store wins; recall is dropped, not queued. Requests while busy = 1 are ignored.
- mem_sel = 00 on a request: no pump activity; err = 1, err_code = 11 at N+1; busy stays 0; done stays 0.
- STORE path:
  - SETUP: mem1_ent = mem_sel[0], mem2_ent = mem_sel[1], busynvc = 1. Lasts SETUP_CYCLES cycles, then go to START.
  - START: vsestart = 1 for exactly START_CYCLES cycles, then go to WAIT_ACK.
  - WAIT_ACK: go to WAIT_DONE when vb_s = 1. After ACK_TIMEOUT cycles without it -> error 01.
  - WAIT_DONE: go to FINISH when vb_s = 0. After STORE_TIMEOUT cycles -> error 10.
- RECALL path: SETUP as above, then rclt = 1 for RECALL_CYCLES cycles, then FINISH. VSESTART is never asserted and VSEBUSY is not checked.
- FINISH (1 cycle):
  - Enables, busynvc, vsestart and rclt are 0.
  - done = 1 for this single cycle.
  - Next cycle: IDLE, busy = 0.
- Error exit, from any state:
  - All pump controls drop to 0 on the next edge.
  - err = 1 and err_code set at that same edge.
  - No done pulse; return to IDLE.
- Timers: each timer reloads on state entry, counts up and saturates; no wrap. A timeout fires on the cycle the count reaches its limit.
- vb_s already 1 on entry to WAIT_ACK (stale busy): counts as ack immediately.
- vb_s dropping during START is ignored.
- resetn low mid-sequence: immediate return to IDLE with every output 0 on that edge; no done and no err.

Test Plan:
- Store, mem_sel = 01, trim_in = 16'hA5C3; pump model raises vsebusy 10 cycles after vsestart and holds it 100 cycles -> mem1_ent = 1, mem2_ent = 0; trim = A5C3 throughout; vsestart high exactly 8 cycles, starting 4 cycles after busy rises; done pulses once; err = 0.
- Recall, mem_sel = 11 -> both enables = 1; rclt high 32 cycles; vsestart never toggles; done 1 cycle after rclt falls; busy is low the following cycle.
- Store with vsebusy stuck at 0 -> err = 1, err_code = 01 after 64 cycles in WAIT_ACK; all pump outputs 0; no done.
- Store with vsebusy stuck at 1 after ack -> err_code = 10 after 4096 cycles in WAIT_DONE; the next valid request clears err.
- store_req and recall_req in the same cycle, then store_req again while busy -> only one store sequence runs and exactly one done pulse occurs; the mem_sel = 00 request sets err_code = 11 without asserting busy.
- resetn driven low for 1 cycle during WAIT_DONE -> all outputs 0 at that edge; no done, no err; the next request runs normally.
